// File: rtl/id_stage_pipe.sv
// RV32I decode with register file, immediate/control generation and an ID/EX register; 1-cycle latency.
// Backpressure: in_ready drops on a held-but-unconsumed output, a load-use hazard or a flush.
module id_stage_pipe #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_instr,
    input  logic [ADDR_SIZE-1:0] in_pc,
    input  logic                 flush,
    input  logic                 wb_en,
    input  logic [REG_SEL-1:0]   wb_sel,
    input  logic [WORD_SIZE-1:0] wb_data,
    input  logic                 ex_mem_read,
    input  logic [REG_SEL-1:0]   ex_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_SIZE-1:0] out_pc,
    output logic [REG_SEL-1:0]   out_rs1,
    output logic [REG_SEL-1:0]   out_rs2,
    output logic [REG_SEL-1:0]   out_rd,
    output logic [WORD_SIZE-1:0] out_rs1_data,
    output logic [WORD_SIZE-1:0] out_rs2_data,
    output logic [WORD_SIZE-1:0] out_immd,
    output logic [2:0]           out_instr_type,
    output logic [2:0]           out_funct3,
    output logic                 out_funct7b5,
    output logic                 out_alu_src_imm,
    output logic                 out_reg_write,
    output logic                 out_mem_read,
    output logic                 out_mem_write,
    output logic                 out_branch,
    output logic                 out_jump,
    output logic                 out_illegal
);

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4, T_J = 3'd5, T_NOP = 3'd7;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] pc;
        logic [REG_SEL-1:0]   rs1;
        logic [REG_SEL-1:0]   rs2;
        logic [REG_SEL-1:0]   rd;
        logic [WORD_SIZE-1:0] rs1_data;
        logic [WORD_SIZE-1:0] rs2_data;
        logic [WORD_SIZE-1:0] immd;
        logic [2:0]           itype;
        logic [2:0]           funct3;
        logic                 funct7b5;
        logic                 alu_src_imm;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
        logic                 jump;
        logic                 illegal;
    } idex_t;

    localparam idex_t IDEX_RESET = '{itype: T_NOP, default: '0};

    logic [WORD_SIZE-1:0] rf_q [NUM_REGS];
    idex_t                idex_q, idex_d, dec;
    logic                 out_valid_q, out_valid_d;

    logic [4:0]           opcode;
    logic                 is_r, is_i, is_s, is_b, is_u, is_j;
    logic [REG_SEL-1:0]   rs1, rs2, rd;
    logic [WORD_SIZE-1:0] rs1_data, rs2_data;
    logic                 hazard, accept;

    assign opcode = in_instr[6:2];
    assign rs1    = REG_SEL'(in_instr[19:15]);
    assign rs2    = REG_SEL'(in_instr[24:20]);
    assign rd     = REG_SEL'(in_instr[11:7]);

    always_comb begin
        is_r = 1'b0; is_i = 1'b0; is_s = 1'b0;
        is_b = 1'b0; is_u = 1'b0; is_j = 1'b0;
        if (in_instr[1:0] == 2'b11) begin
            case (opcode)
                5'b01100:                   is_r = 1'b1;
                5'b00100, 5'b00000, 5'b11001: is_i = 1'b1;
                5'b01000:                   is_s = 1'b1;
                5'b11000:                   is_b = 1'b1;
                5'b01101, 5'b00101:         is_u = 1'b1;
                5'b11011:                   is_j = 1'b1;
                default: ;
            endcase
        end
    end

    // Write-back data is forwarded so a same-cycle write is never missed by the read.
    assign rs1_data = (rs1 == '0) ? '0 :
                      (wb_en && wb_sel == rs1) ? wb_data : rf_q[rs1];
    assign rs2_data = (rs2 == '0) ? '0 :
                      (wb_en && wb_sel == rs2) ? wb_data : rf_q[rs2];

    assign hazard = in_valid && ex_mem_read && (ex_rd != '0) &&
                    (((is_r || is_i || is_s || is_b) && ex_rd == rs1) ||
                     ((is_r || is_s || is_b) && ex_rd == rs2));
    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.funct3   = in_instr[14:12];
        dec.funct7b5 = in_instr[30];
        dec.itype    = T_NOP;
        if (is_r) dec.itype = T_R;
        if (is_i) dec.itype = T_I;
        if (is_s) dec.itype = T_S;
        if (is_b) dec.itype = T_B;
        if (is_u) dec.itype = T_U;
        if (is_j) dec.itype = T_J;
        if (is_i) dec.immd = {{20{in_instr[31]}}, in_instr[31:20]};
        if (is_s) dec.immd = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        if (is_b) dec.immd = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
        if (is_u) dec.immd = {in_instr[31:12], 12'b0};
        if (is_j) dec.immd = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
        dec.alu_src_imm = !(is_r || is_b);
        dec.reg_write   = is_r || is_i || is_u || is_j;
        dec.mem_read    = is_i && (opcode == 5'b00000);
        dec.mem_write   = is_s;
        dec.branch      = is_b;
        dec.jump        = is_j || (is_i && opcode == 5'b11001);
        dec.illegal     = !(is_r || is_i || is_s || is_b || is_u || is_j);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        idex_d      = idex_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            idex_d      = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            idex_q      <= IDEX_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            idex_q      <= idex_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (wb_en && wb_sel != '0) begin
            rf_q[wb_sel] <= wb_data;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_pc          = idex_q.pc;
    assign out_rs1         = idex_q.rs1;
    assign out_rs2         = idex_q.rs2;
    assign out_rd          = idex_q.rd;
    assign out_rs1_data    = idex_q.rs1_data;
    assign out_rs2_data    = idex_q.rs2_data;
    assign out_immd        = idex_q.immd;
    assign out_instr_type  = idex_q.itype;
    assign out_funct3      = idex_q.funct3;
    assign out_funct7b5    = idex_q.funct7b5;
    assign out_alu_src_imm = idex_q.alu_src_imm;
    assign out_reg_write   = idex_q.reg_write;
    assign out_mem_read    = idex_q.mem_read;
    assign out_mem_write   = idex_q.mem_write;
    assign out_branch      = idex_q.branch;
    assign out_jump        = idex_q.jump;
    assign out_illegal     = idex_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, immediates, register file, hazards, handshake, flush and reset.
module tb_id_stage_pipe;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr;
    logic [9:0]  in_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        out_valid, out_ready;
    logic [9:0]  out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_rs1_data, out_rs2_data, out_immd;
    logic [2:0]  out_instr_type, out_funct3;
    logic        out_funct7b5, out_alu_src_imm, out_reg_write, out_mem_read;
    logic        out_mem_write, out_branch, out_jump, out_illegal;

    int n_chk = 0;
    int n_fail = 0;

    id_stage_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_immd(out_immd),
        .out_instr_type(out_instr_type), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_alu_src_imm(out_alu_src_imm), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
        n_chk++; if (out_instr_type !== 3'd7) begin n_fail++; $display("FAIL reset_type: got %0d want 7", out_instr_type); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
        n_chk++; if (out_immd !== 32'h0) begin n_fail++; $display("FAIL reset_immd: got %08h want 0", out_immd); end
        n_chk++; if (out_reg_write !== 1'b0 || out_illegal !== 1'b0 || out_alu_src_imm !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got rw=%0h ill=%0h asi=%0h want 0", out_reg_write, out_illegal, out_alu_src_imm); end
        n_chk++; if (out_pc !== 10'h0 || out_rd !== 5'h0) begin n_fail++; $display("FAIL reset_pc_rd: got pc=%0h rd=%0h want 0", out_pc, out_rd); end
    endtask

    task automatic test_regfile_zero;
        logic [4:0] r;
        out_ready = 1'b1;
        for (int i = 1; i < 32; i++) begin
            r = i[4:0];
            in_valid = 1'b1;
            in_instr = {7'b0, r, r, 3'b0, 5'd0, 7'h33};
            tick;
            n_chk++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0) begin n_fail++; $display("FAIL rf_zero x%0d: got v=%0h d1=%08h d2=%08h want 1/0/0", i, out_valid, out_rs1_data, out_rs2_data); end
        end
        in_valid = 1'b0;
        tick;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_after_stream: got %0h want 0", out_valid); end
    endtask

    task automatic test_addi;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 10'h004;
        tick;
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0h want 1", out_valid); end
        n_chk++; if (out_instr_type !== 3'd1) begin n_fail++; $display("FAIL addi_type: got %0d want 1", out_instr_type); end
        n_chk++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin n_fail++; $display("FAIL addi_regs: got rd=%0d rs1=%0d want 1/0", out_rd, out_rs1); end
        n_chk++; if (out_immd !== 32'd5) begin n_fail++; $display("FAIL addi_immd: got %08h want 5", out_immd); end
        n_chk++; if (out_reg_write !== 1'b1 || out_alu_src_imm !== 1'b1 || out_mem_read !== 1'b0 || out_jump !== 1'b0) begin n_fail++; $display("FAIL addi_ctrl: got rw=%0h asi=%0h mr=%0h j=%0h want 1/1/0/0", out_reg_write, out_alu_src_imm, out_mem_read, out_jump); end
        n_chk++; if (out_pc !== 10'h004) begin n_fail++; $display("FAIL addi_pc: got %0h want 4", out_pc); end
    endtask

    task automatic test_branch_lui;
        in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 10'h008;
        tick;
        n_chk++; if (out_immd !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL beq_immd: got %08h want FFFFFFFC", out_immd); end
        n_chk++; if (out_branch !== 1'b1 || out_instr_type !== 3'd3 || out_reg_write !== 1'b0 || out_alu_src_imm !== 1'b0) begin n_fail++; $display("FAIL beq_ctrl: got br=%0h t=%0d rw=%0h asi=%0h want 1/3/0/0", out_branch, out_instr_type, out_reg_write, out_alu_src_imm); end
        in_instr = 32'h123453B7; in_pc = 10'h00C;
        tick;
        in_valid = 1'b0;
        n_chk++; if (out_immd !== 32'h12345000) begin n_fail++; $display("FAIL lui_immd: got %08h want 12345000", out_immd); end
        n_chk++; if (out_instr_type !== 3'd4 || out_rd !== 5'd7 || out_reg_write !== 1'b1 || out_branch !== 1'b0) begin n_fail++; $display("FAIL lui_ctrl: got t=%0d rd=%0d rw=%0h br=%0h want 4/7/1/0", out_instr_type, out_rd, out_reg_write, out_branch); end
    endtask

    task automatic test_decode_mix;
        in_valid = 1'b1;
        in_instr = 32'h00812203;
        tick;
        n_chk++; if (out_instr_type !== 3'd1 || out_mem_read !== 1'b1 || out_funct3 !== 3'd2 || out_immd !== 32'd8 || out_rd !== 5'd4) begin n_fail++; $display("FAIL lw_decode: got t=%0d mr=%0h f3=%0d imm=%08h rd=%0d want 1/1/2/8/4", out_instr_type, out_mem_read, out_funct3, out_immd, out_rd); end
        in_instr = 32'hFE512C23;
        tick;
        n_chk++; if (out_instr_type !== 3'd2 || out_mem_write !== 1'b1 || out_immd !== 32'hFFFFFFF8 || out_reg_write !== 1'b0 || out_rs2 !== 5'd5) begin n_fail++; $display("FAIL sw_decode: got t=%0d mw=%0h imm=%08h rw=%0h rs2=%0d want 2/1/FFFFFFF8/0/5", out_instr_type, out_mem_write, out_immd, out_reg_write, out_rs2); end
        in_instr = 32'h008000EF;
        tick;
        n_chk++; if (out_instr_type !== 3'd5 || out_jump !== 1'b1 || out_immd !== 32'd8 || out_reg_write !== 1'b1 || out_rd !== 5'd1) begin n_fail++; $display("FAIL jal_decode: got t=%0d j=%0h imm=%08h rw=%0h rd=%0d want 5/1/8/1/1", out_instr_type, out_jump, out_immd, out_reg_write, out_rd); end
        in_instr = 32'h000080E7;
        tick;
        n_chk++; if (out_instr_type !== 3'd1 || out_jump !== 1'b1 || out_mem_read !== 1'b0 || out_immd !== 32'd0) begin n_fail++; $display("FAIL jalr_decode: got t=%0d j=%0h mr=%0h imm=%08h want 1/1/0/0", out_instr_type, out_jump, out_mem_read, out_immd); end
        in_instr = 32'h401101B3;
        tick;
        n_chk++; if (out_instr_type !== 3'd0 || out_funct7b5 !== 1'b1 || out_alu_src_imm !== 1'b0 || out_immd !== 32'd0) begin n_fail++; $display("FAIL sub_decode: got t=%0d f7b5=%0h asi=%0h imm=%08h want 0/1/0/0", out_instr_type, out_funct7b5, out_alu_src_imm, out_immd); end
        in_instr = 32'h00001097;
        tick;
        in_valid = 1'b0;
        n_chk++; if (out_instr_type !== 3'd4 || out_immd !== 32'h00001000 || out_jump !== 1'b0) begin n_fail++; $display("FAIL auipc_decode: got t=%0d imm=%08h j=%0h want 4/00001000/0", out_instr_type, out_immd, out_jump); end
    endtask

    task automatic test_load_use;
        in_valid = 1'b1; in_instr = 32'h123453B7;
        ex_mem_read = 1'b1; ex_rd = 5'd8;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lui_no_hazard: got in_ready=%0h want 1", in_ready); end
        tick;
        in_instr = 32'h001101B3; ex_rd = 5'd2;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_rs1: got in_ready=%0h want 0", in_ready); end
        tick;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble: got out_valid=%0h want 0", out_valid); end
        ex_rd = 5'd1;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_rs2: got in_ready=%0h want 0", in_ready); end
        ex_rd = 5'd3;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL no_hazard_rd: got in_ready=%0h want 1", in_ready); end
        ex_rd = 5'd2; ex_mem_read = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_release: got in_ready=%0h want 1", in_ready); end
        tick;
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_rs1 !== 5'd2 || out_rs2 !== 5'd1 || out_instr_type !== 3'd0) begin n_fail++; $display("FAIL add_after_stall: got v=%0h rd=%0d rs1=%0d rs2=%0d t=%0d want 1/3/2/1/0", out_valid, out_rd, out_rs1, out_rs2, out_instr_type); end
    endtask

    task automatic test_bypass;
        wb_en = 1'b1; wb_sel = 5'd5; wb_data = 32'hDEADBEEF;
        in_valid = 1'b1; in_instr = 32'h00028333;
        tick;
        wb_en = 1'b0;
        n_chk++; if (out_rs1_data !== 32'hDEADBEEF || out_rs2_data !== 32'h0 || out_rd !== 5'd6) begin n_fail++; $display("FAIL bypass_rs1: got d1=%08h d2=%08h rd=%0d want DEADBEEF/0/6", out_rs1_data, out_rs2_data, out_rd); end
        tick;
        n_chk++; if (out_rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rf_read_x5: got %08h want DEADBEEF", out_rs1_data); end
        wb_en = 1'b1; wb_sel = 5'd0; wb_data = 32'h12345678; in_instr = 32'h00000333;
        tick;
        wb_en = 1'b0;
        n_chk++; if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0) begin n_fail++; $display("FAIL x0_bypass: got d1=%08h d2=%08h want 0/0", out_rs1_data, out_rs2_data); end
        tick;
        n_chk++; if (out_rs1_data !== 32'h0) begin n_fail++; $display("FAIL x0_read: got %08h want 0", out_rs1_data); end
        wb_en = 1'b1; wb_sel = 5'd7; wb_data = 32'h0BADF00D; in_instr = 32'h00700333;
        tick;
        wb_en = 1'b0; in_valid = 1'b0;
        n_chk++; if (out_rs2_data !== 32'h0BADF00D || out_rs1_data !== 32'h0) begin n_fail++; $display("FAIL bypass_rs2: got d1=%08h d2=%08h want 0/0BADF00D", out_rs1_data, out_rs2_data); end
    endtask

    task automatic test_backpressure_flush;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 10'h020; out_ready = 1'b1;
        tick;
        out_ready = 1'b0; in_instr = 32'h123453B7; in_pc = 10'h024;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0h want 0", in_ready); end
        for (int k = 0; k < 2; k++) begin
            tick;
            n_chk++; if (out_valid !== 1'b1 || out_immd !== 32'd5 || out_pc !== 10'h020 || out_instr_type !== 3'd1) begin n_fail++; $display("FAIL bp_hold%0d: got v=%0h imm=%08h pc=%0h t=%0d want 1/5/20/1", k, out_valid, out_immd, out_pc, out_instr_type); end
        end
        out_ready = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got in_ready=%0h want 1", in_ready); end
        tick;
        n_chk++; if (out_immd !== 32'h12345000 || out_pc !== 10'h024) begin n_fail++; $display("FAIL bp_next: got imm=%08h pc=%0h want 12345000/24", out_immd, out_pc); end
        out_ready = 1'b0; in_instr = 32'hFE000EE3; flush = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0h want 0", in_ready); end
        tick;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0h want 0", out_valid); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %0h want 0", out_valid); end
    endtask

    task automatic test_illegal;
        in_valid = 1'b1; in_instr = 32'h00000000;
        tick;
        n_chk++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_instr_type !== 3'd7) begin n_fail++; $display("FAIL zero_illegal: got v=%0h ill=%0h t=%0d want 1/1/7", out_valid, out_illegal, out_instr_type); end
        n_chk++; if (out_reg_write !== 1'b0 || out_mem_read !== 1'b0 || out_immd !== 32'h0) begin n_fail++; $display("FAIL zero_ctrl: got rw=%0h mr=%0h imm=%08h want 0/0/0", out_reg_write, out_mem_read, out_immd); end
        in_instr = 32'h00812200;
        tick;
        n_chk++; if (out_illegal !== 1'b1 || out_mem_read !== 1'b0 || out_instr_type !== 3'd7) begin n_fail++; $display("FAIL lw_bad_lsb: got ill=%0h mr=%0h t=%0d want 1/0/7", out_illegal, out_mem_read, out_instr_type); end
        in_instr = 32'h0000007F;
        tick;
        in_valid = 1'b0;
        n_chk++; if (out_illegal !== 1'b1 || out_jump !== 1'b0 || out_branch !== 1'b0 || out_mem_write !== 1'b0) begin n_fail++; $display("FAIL bad_opcode: got ill=%0h j=%0h br=%0h mw=%0h want 1/0/0/0", out_illegal, out_jump, out_branch, out_mem_write); end
    endtask

    task automatic test_reset_mid_stall;
        wb_en = 1'b1; wb_sel = 5'd9; wb_data = 32'h00000055; in_valid = 1'b0;
        tick;
        wb_en = 1'b0; in_valid = 1'b1; in_instr = 32'h00048333;
        tick;
        n_chk++; if (out_rs1_data !== 32'h55) begin n_fail++; $display("FAIL x9_written: got %08h want 55", out_rs1_data); end
        out_ready = 1'b0; in_instr = 32'h001101B3; ex_mem_read = 1'b1; ex_rd = 5'd2;
        tick;
        n_chk++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h55) begin n_fail++; $display("FAIL stall_hold: got v=%0h d1=%08h want 1/55", out_valid, out_rs1_data); end
        rst = 1'b1;
        tick;
        rst = 1'b0; ex_mem_read = 1'b0; in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || out_instr_type !== 3'd7 || out_rs1_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset: got v=%0h t=%0d d1=%08h want 0/7/0", out_valid, out_instr_type, out_rs1_data); end
        in_valid = 1'b1; in_instr = 32'h00048333; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h0) begin n_fail++; $display("FAIL rf_cleared: got v=%0h d1=%08h want 1/0", out_valid, out_rs1_data); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_sel = '0; wb_data = '0; ex_mem_read = 1'b0; ex_rd = '0;
        out_ready = 1'b1;
        test_reset;
        test_regfile_zero;
        test_addi;
        test_branch_lui;
        test_decode_mix;
        test_load_use;
        test_bypass;
        test_backpressure_flush;
        test_illegal;
        test_reset_mid_stall;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Pipelined successor to the combinational decode stage.
- Decodes one RV32I instruction per cycle, reads two operands from an internal register file, and generates the sign-extended immediate and control bits.
- Registers all results into an ID/EX pipeline register under a valid/ready handshake, with load-use stall detection, flush, and write-back bypass.
- Sits between the IF stage (upstream) and the EX stage (downstream).

Parameters:
- WORD_SIZE, 32: datapath and instruction width.
- NUM_REGS, 32: register file depth; entry 0 is hard-wired to zero.
- REG_SEL, $clog2(NUM_REGS): register index width.
- ADDR_SIZE, 10: PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  WORD_SIZE  instruction word.
- in_pc  in  ADDR_SIZE  PC of in_instr.
- flush  in  1  kill the held and incoming instruction (branch redirect).
- wb_en  in  1  write-back enable.
- wb_sel  in  REG_SEL  write-back destination.
- wb_data  in  WORD_SIZE  write-back data.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_rd  in  REG_SEL  destination of the instruction currently in EX.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX consumes the held instruction.
- out_pc  out  ADDR_SIZE  registered PC.
- out_rs1, out_rs2, out_rd  out  REG_SEL each  registered indices.
- out_rs1_data, out_rs2_data  out  WORD_SIZE each  registered operands.
- out_immd  out  WORD_SIZE  sign-extended immediate.
- out_instr_type  out  3  R=0, I=1, S=2, B=3, U=4, J=5, NOP/illegal=7.
- out_funct3  out  3  instr[14:12].
- out_funct7b5  out  1  instr[30].
- out_alu_src_imm, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal  out  1 each  control bits.

Behaviour:
- Reset: out_valid=0; every out_* data/control = 0, except out_instr_type=7. All registers cleared to 0.
- Opcode decode (instr[6:2]):
  - 01100 → R.
  - 00100, 00000, 11001 → I.
  - 01000 → S.
  - 11000 → B.
  - 01101, 00101 → U.
  - 11011 → J.
  - Anything else, or instr[1:0]≠2'b11 → type 7, out_illegal=1, all write/mem/branch/jump controls 0. The instruction still passes with out_valid=1.
- Immediate generation:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R and type 7: 0.
- Control bits:
  - reg_write = R | I | U | J.
  - mem_read = opcode 00000.
  - mem_write = S.
  - branch = B.
  - jump = J | opcode 11001.
  - alu_src_imm = all types except R and B.
- Register file:
  - Two combinational read ports, one write port.
  - Writes occur at the clock edge when wb_en=1 and wb_sel≠0; writes to x0 are ignored.
  - Reads of x0 return 0.
- Bypass: if wb_en=1, wb_sel≠0 and wb_sel==rs, the captured operand is wb_data (same-cycle write-through).
- Register usage:
  - rs1 is used for R, I, S, B.
  - rs2 is used for R, S, B.
- Hazard: hazard = in_valid & ex_mem_read & ex_rd≠0 & ((rs1 used & ex_rd==rs1) | (rs2 used & ex_rd==rs2)).
- Handshake:
  - in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
  - Accept (in_valid & in_ready): the ID/EX register loads at the next edge and out_valid=1. Latency is 1 cycle.
  - No accept with out_ready=1: out_valid→0 (a bubble is inserted during a stall).
  - No accept with out_ready=0 and out_valid=1: all outputs hold.
- Flush: next edge out_valid=0, no accept that cycle; flush has priority over accept and hold.
- rst has priority over everything; rst asserted mid-stall clears the pipeline register and the register file.

Test Plan:
- Reset → out_valid=0, out_instr_type=7, in_ready=1. Any read of x1..x31 returns 0.
- in_instr=0x00500093 (addi x1,x0,5), out_ready=1 → next cycle:
  - out_valid=1, type=1, out_rd=1, out_immd=5.
  - out_reg_write=1, out_alu_src_imm=1.
- 0xFE000EE3 (beq x0,x0,-4) → out_immd=0xFFFFFFFC, out_branch=1, type=3, out_reg_write=0. Also 0x123453B7 (lui x7) → out_immd=0x12345000, type=4.
- Load-use stall:
  - in_instr=0x001101B3 (add x3,x2,x1) with ex_mem_read=1, ex_rd=2 → in_ready=0 and out_valid drops to 0 the next cycle.
  - Deassert ex_mem_read → accepted, out_rd=3.
- Bypass: wb_en=1, wb_sel=5, wb_data=0xDEADBEEF in the same cycle as 0x00028333 (add x6,x5,x0) → out_rs1_data=0xDEADBEEF. A later read of x5 also returns 0xDEADBEEF. A write to x0 reads back 0.
- Backpressure and flush:
  - out_ready=0 while valid → outputs stable, in_ready=0.
  - flush=1 → next cycle out_valid=0 and the incoming instruction is dropped.
  - in_instr=0x00000000 → out_illegal=1, type=7.
